// File: rtl/algo_1r1wor2w_req_sched_pkg.sv
// -----------------------------------------------------------------------------
// algo_sched_pkg
// Shared types and constants for the 1R1W-or-2W request scheduler.
//   clnt_id_t : client index (default BITCLNT = 2, i.e. 4 clients)
//   op_e      : kind of operation chosen for a pick slot
//   SLOT_RD   : memory slot that always carries the read
//   SLOT_WR2  : memory slot used by a write that shares the cycle
// -----------------------------------------------------------------------------
package algo_sched_pkg;

   localparam int unsigned BITCLNT = 2;

   typedef logic [BITCLNT-1:0] clnt_id_t;

   typedef enum logic [1:0] {
      OP_NONE = 2'd0,
      OP_RD   = 2'd1,
      OP_WR   = 2'd2
   } op_e;

   localparam int unsigned SLOT_RD  = 0;
   localparam int unsigned SLOT_WR2 = 1;

endpackage

// File: rtl/algo_1r1wor2w_req_sched_if.sv
// -----------------------------------------------------------------------------
// algo_1r1wor2w_req_sched_if
// Bundles the client request/response bus, the memory-side bus and the
// performance counters of the scheduler.
//   slave  : scheduler side (consumes client requests, drives memory ops)
//   master : environment side (clients + memory)
// Signals:
//   cl_vld/cl_rdy/cl_wr/cl_addr/cl_din : per-client request channel
//   rsp_vld/rsp_dout                    : one-hot read response, shared data
//   mem_ready/read/write/addr/din       : memory op issue
//   rd_vld/rd_dout                      : memory read return
//   sched_err                           : sticky tag-pipe disagreement
//   perf_rd_cnt/perf_wr_cnt/perf_stall_cnt : counters (0 when disabled)
// -----------------------------------------------------------------------------
interface algo_1r1wor2w_req_sched_if #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned BITADDR = 13,
   parameter int unsigned NUMCLNT = 4
);
   logic [NUMCLNT-1:0]         cl_vld;
   logic [NUMCLNT-1:0]         cl_rdy;
   logic [NUMCLNT-1:0]         cl_wr;
   logic [NUMCLNT*BITADDR-1:0] cl_addr;
   logic [NUMCLNT*WIDTH-1:0]   cl_din;
   logic [NUMCLNT-1:0]         rsp_vld;
   logic [WIDTH-1:0]           rsp_dout;
   logic                       mem_ready;
   logic                       read;
   logic [1:0]                 write;
   logic [2*BITADDR-1:0]       addr;
   logic [2*WIDTH-1:0]         din;
   logic                       rd_vld;
   logic [WIDTH-1:0]           rd_dout;
   logic                       sched_err;
   logic [31:0]                perf_rd_cnt;
   logic [31:0]                perf_wr_cnt;
   logic [31:0]                perf_stall_cnt;

   modport slave (
      input  cl_vld, cl_wr, cl_addr, cl_din, mem_ready, rd_vld, rd_dout,
      output cl_rdy, rsp_vld, rsp_dout, read, write, addr, din, sched_err,
             perf_rd_cnt, perf_wr_cnt, perf_stall_cnt
   );

   modport master (
      output cl_vld, cl_wr, cl_addr, cl_din, mem_ready, rd_vld, rd_dout,
      input  cl_rdy, rsp_vld, rsp_dout, read, write, addr, din, sched_err,
             perf_rd_cnt, perf_wr_cnt, perf_stall_cnt
   );
endinterface

// File: rtl/algo_1r1wor2w_req_sched_rr_pick.sv
// -----------------------------------------------------------------------------
// algo_rr_pick
// Masked find-first: scans i_req starting at i_start, wrapping at N, and
// returns the first set index.
//   i_req   : candidate mask (already qualified by the caller)
//   i_start : scan start index
//   o_found : any candidate set
//   o_idx   : index of the first candidate in scan order
// -----------------------------------------------------------------------------
module algo_rr_pick #(
   parameter int unsigned N = 4,
   parameter int unsigned B = 2
) (
   input  logic [N-1:0] i_req,
   input  logic [B-1:0] i_start,
   output logic         o_found,
   output logic [B-1:0] o_idx
);

   always_comb begin
      int unsigned v_j;
      logic [B-1:0] v_jb;
      o_found = 1'b0;
      o_idx   = '0;
      v_j     = 0;
      v_jb    = '0;
      for (int unsigned k = 0; k < N; k++) begin
         v_j  = ({{(32-B){1'b0}}, i_start} + k) % N;
         v_jb = v_j[B-1:0];
         if (!o_found && i_req[v_jb]) begin
            o_found = 1'b1;
            o_idx   = v_jb;
         end
      end
   end

endmodule

// File: rtl/algo_1r1wor2w_req_sched.sv
// -----------------------------------------------------------------------------
// algo_1r1wor2w_req_sched
// Round-robin scheduler merging NUMCLNT client streams into at most two memory
// ops per cycle: 1 read + 1 write, or 2 writes (never 2 reads). Read data is
// routed back to the issuing client through a fixed-latency tag pipe.
// Ports:
//   clk  : clock
//   rst  : asynchronous reset, active high
//   bus  : algo_1r1wor2w_req_sched_if.slave (client, memory, perf signals)
// Optional feature: define ALGO_SCHED_PERF_EN to build the saturating
// perf_rd_cnt / perf_wr_cnt / perf_stall_cnt counters; otherwise they read 0.
// -----------------------------------------------------------------------------
module algo_1r1wor2w_req_sched
   import algo_sched_pkg::*;
#(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned BITADDR = 13,
   parameter int unsigned NUMCLNT = 4,
   parameter int unsigned BITCLNT = 2,
   parameter int unsigned RD_LAT  = 3
) (
   input logic                      clk,
   input logic                      rst,
   algo_1r1wor2w_req_sched_if.slave bus
);

   logic [BITADDR-1:0]           w_caddr [NUMCLNT];
   logic [WIDTH-1:0]             w_cdin  [NUMCLNT];
   logic [NUMCLNT-1:0]           w_elig;
   logic [NUMCLNT-1:0]           w_req1;
   logic [NUMCLNT-1:0]           w_req2;
   logic [NUMCLNT-1:0]           w_p1_oh;
   logic [NUMCLNT-1:0]           w_p2_oh;
   logic [NUMCLNT-1:0]           w_cl_rdy;
   logic                         w_p1_found;
   logic                         w_p2_found;
   logic [BITCLNT-1:0]           w_p1_idx;
   logic [BITCLNT-1:0]           w_p2_idx;
   logic [BITCLNT-1:0]           w_p1_next;
   logic [BITCLNT-1:0]           w_p2_next;
   op_e                          w_op1;
   op_e                          w_op2;

   logic                         w_read_n;
   logic [1:0]                   w_write_n;
   logic [BITADDR-1:0]           w_saddr [2];
   logic [WIDTH-1:0]             w_sdin  [2];
   logic [BITCLNT-1:0]           w_tag_in_id;

   logic [BITCLNT-1:0]           r_ptr;
   logic                         r_read;
   logic [1:0]                   r_write;
   logic [2*BITADDR-1:0]         r_addr;
   logic [2*WIDTH-1:0]           r_din;
   logic [RD_LAT:0]              r_tag_vld;
   logic [RD_LAT:0][BITCLNT-1:0] r_tag_id;
   logic                         r_sched_err;

   logic                         w_tag_out_vld;
   logic [BITCLNT-1:0]           w_tag_out_id;
   logic                         w_rsp_fire;

   // Per-client field extraction and pick2 eligibility relative to pick1.
   for (genvar g = 0; g < NUMCLNT; g++) begin : g_clnt
      assign w_caddr[g] = bus.cl_addr[g*BITADDR +: BITADDR];
      assign w_cdin[g]  = bus.cl_din[g*WIDTH +: WIDTH];
      assign w_elig[g]  = !((!bus.cl_wr[w_p1_idx] && !bus.cl_wr[g]) ||
                            (bus.cl_wr[w_p1_idx] && bus.cl_wr[g] &&
                             (w_caddr[g] == w_caddr[w_p1_idx])));
   end

   // No grants while memory is initialising or the block is held in reset.
   assign w_req1 = (bus.mem_ready && !rst) ? bus.cl_vld : '0;

   algo_rr_pick #(.N(NUMCLNT), .B(BITCLNT)) u_pick1 (
      .i_req   (w_req1),
      .i_start (r_ptr),
      .o_found (w_p1_found),
      .o_idx   (w_p1_idx)
   );

   // pick2 scans from just after pick1; pick1 itself is masked out so a
   // full wrap cannot select it again.
   assign w_p1_oh   = w_p1_found ? (NUMCLNT'(1) << w_p1_idx) : '0;
   assign w_p1_next = (w_p1_idx == BITCLNT'(NUMCLNT-1)) ? '0 : w_p1_idx + 1'b1;
   assign w_req2    = w_req1 & w_elig & ~w_p1_oh & {NUMCLNT{w_p1_found}};

   algo_rr_pick #(.N(NUMCLNT), .B(BITCLNT)) u_pick2 (
      .i_req   (w_req2),
      .i_start (w_p1_next),
      .o_found (w_p2_found),
      .o_idx   (w_p2_idx)
   );

   assign w_p2_oh   = w_p2_found ? (NUMCLNT'(1) << w_p2_idx) : '0;
   assign w_p2_next = (w_p2_idx == BITCLNT'(NUMCLNT-1)) ? '0 : w_p2_idx + 1'b1;
   assign w_cl_rdy  = w_p1_oh | w_p2_oh;

   assign w_op1 = !w_p1_found ? OP_NONE : (bus.cl_wr[w_p1_idx] ? OP_WR : OP_RD);
   assign w_op2 = !w_p2_found ? OP_NONE : (bus.cl_wr[w_p2_idx] ? OP_WR : OP_RD);

   // Slot mapping: a read always owns slot 0, a write sharing the cycle with
   // a read moves to slot 1, two writes keep rr order, a lone write uses slot 0.
   always_comb begin
      w_read_n    = 1'b0;
      w_write_n   = '0;
      w_saddr[0]  = '0;
      w_saddr[1]  = '0;
      w_sdin[0]   = '0;
      w_sdin[1]   = '0;
      w_tag_in_id = w_p1_idx;
      if (w_op1 == OP_RD) begin
         w_read_n         = 1'b1;
         w_saddr[SLOT_RD] = w_caddr[w_p1_idx];
         if (w_op2 == OP_WR) begin
            w_write_n[SLOT_WR2] = 1'b1;
            w_saddr[SLOT_WR2]   = w_caddr[w_p2_idx];
            w_sdin[SLOT_WR2]    = w_cdin[w_p2_idx];
         end
      end else if (w_op1 == OP_WR) begin
         if (w_op2 == OP_RD) begin
            w_read_n            = 1'b1;
            w_tag_in_id         = w_p2_idx;
            w_saddr[SLOT_RD]    = w_caddr[w_p2_idx];
            w_write_n[SLOT_WR2] = 1'b1;
            w_saddr[SLOT_WR2]   = w_caddr[w_p1_idx];
            w_sdin[SLOT_WR2]    = w_cdin[w_p1_idx];
         end else if (w_op2 == OP_WR) begin
            w_write_n  = 2'b11;
            w_saddr[0] = w_caddr[w_p1_idx];
            w_sdin[0]  = w_cdin[w_p1_idx];
            w_saddr[1] = w_caddr[w_p2_idx];
            w_sdin[1]  = w_cdin[w_p2_idx];
         end else begin
            w_write_n[0] = 1'b1;
            w_saddr[0]   = w_caddr[w_p1_idx];
            w_sdin[0]    = w_cdin[w_p1_idx];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ptr   <= '0;
         r_read  <= 1'b0;
         r_write <= '0;
         r_addr  <= '0;
         r_din   <= '0;
      end else begin
         if (w_p1_found) begin
            r_ptr <= w_p2_found ? w_p2_next : w_p1_next;
         end
         r_read  <= w_read_n;
         r_write <= w_write_n;
         r_addr  <= {w_saddr[1], w_saddr[0]};
         r_din   <= {w_sdin[1], w_sdin[0]};
      end
   end

   // Stage 0 is loaded at acceptance, so the last of RD_LAT+1 stages lines up
   // with rd_vld returned RD_LAT cycles after the registered read issue.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tag_vld <= '0;
         r_tag_id  <= '0;
      end else begin
         r_tag_vld <= {r_tag_vld[RD_LAT-1:0], w_read_n};
         r_tag_id  <= {r_tag_id[RD_LAT-1:0], w_tag_in_id};
      end
   end

   assign w_tag_out_vld = r_tag_vld[RD_LAT];
   assign w_tag_out_id  = r_tag_id[RD_LAT];
   assign w_rsp_fire    = w_tag_out_vld && bus.rd_vld;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sched_err <= 1'b0;
      end else if (bus.rd_vld != w_tag_out_vld) begin
         r_sched_err <= 1'b1;
      end
   end

   assign bus.cl_rdy    = w_cl_rdy;
   assign bus.read      = r_read;
   assign bus.write     = r_write;
   assign bus.addr      = r_addr;
   assign bus.din       = r_din;
   assign bus.rsp_vld   = w_rsp_fire ? (NUMCLNT'(1) << w_tag_out_id) : '0;
   assign bus.rsp_dout  = w_rsp_fire ? bus.rd_dout : '0;
   assign bus.sched_err = r_sched_err;

`ifdef ALGO_SCHED_PERF_EN
   logic [31:0] r_perf_rd;
   logic [31:0] r_perf_wr;
   logic [31:0] r_perf_stall;
   logic [1:0]  w_wr_inc;

   assign w_wr_inc = {1'b0, r_write[0]} + {1'b0, r_write[1]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_perf_rd    <= '0;
         r_perf_wr    <= '0;
         r_perf_stall <= '0;
      end else begin
         if (r_read && (r_perf_rd != '1)) begin
            r_perf_rd <= r_perf_rd + 32'd1;
         end
         if (r_perf_wr > (32'hFFFF_FFFF - 32'(w_wr_inc))) begin
            r_perf_wr <= '1;
         end else begin
            r_perf_wr <= r_perf_wr + 32'(w_wr_inc);
         end
         if ((|bus.cl_vld) && !(|w_cl_rdy) && (r_perf_stall != '1)) begin
            r_perf_stall <= r_perf_stall + 32'd1;
         end
      end
   end

   assign bus.perf_rd_cnt    = r_perf_rd;
   assign bus.perf_wr_cnt    = r_perf_wr;
   assign bus.perf_stall_cnt = r_perf_stall;
`else
   assign bus.perf_rd_cnt    = '0;
   assign bus.perf_wr_cnt    = '0;
   assign bus.perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_algo_1r1wor2w_req_sched.sv
// -----------------------------------------------------------------------------
// tb_algo_1r1wor2w_req_sched
// Self-checking bench: a fixed-latency memory model returns a known pattern
// per address, read grants push the expected response into a queue and a
// monitor pops and compares whenever rsp_vld fires.
// -----------------------------------------------------------------------------
module tb_algo_1r1wor2w_req_sched;
   import algo_sched_pkg::*;

   localparam int unsigned WIDTH   = 32;
   localparam int unsigned BITADDR = 13;
   localparam int unsigned NUMCLNT = 4;
   localparam int unsigned NBITCL  = 2;
   localparam int unsigned RD_LAT  = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic inj = 1'b0;
   always #5 clk = ~clk;

   algo_1r1wor2w_req_sched_if #(.WIDTH(WIDTH), .BITADDR(BITADDR), .NUMCLNT(NUMCLNT)) bus ();

   algo_1r1wor2w_req_sched #(
      .WIDTH(WIDTH), .BITADDR(BITADDR), .NUMCLNT(NUMCLNT), .BITCLNT(NBITCL), .RD_LAT(RD_LAT)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct packed {
      clnt_id_t         id;
      logic [WIDTH-1:0] data;
   } rsp_t;

   rsp_t sb_q[$];
   rsp_t mon_e;
   int   vectors     = 0;
   int   miscompares = 0;

   function automatic logic [WIDTH-1:0] rom(input logic [BITADDR-1:0] a);
      return {a, 3'b101, a, 3'b011};
   endfunction

   // Memory model: read visible in cycle n returns rd_vld/rd_dout in n+RD_LAT.
   logic [RD_LAT-1:0]              m_vld;
   logic [RD_LAT-1:0][BITADDR-1:0] m_addr;
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_vld  <= '0;
         m_addr <= '0;
      end else begin
         m_vld  <= {m_vld[RD_LAT-2:0], bus.read};
         m_addr <= {m_addr[RD_LAT-2:0], bus.addr[BITADDR-1:0]};
      end
   end
   assign bus.rd_vld  = m_vld[RD_LAT-1] | inj;
   assign bus.rd_dout = m_vld[RD_LAT-1] ? rom(m_addr[RD_LAT-1]) : '0;

   // Scoreboard consumer.
   always @(negedge clk) begin
      if (!rst && (bus.rsp_vld != '0)) begin
         vectors++;
         if (sb_q.size() == 0) begin
            miscompares++;
            $display("FAIL rsp_unexpected: rsp_vld=%b dout=%h, no read outstanding", bus.rsp_vld, bus.rsp_dout);
         end else begin
            mon_e = sb_q.pop_front();
            if (bus.rsp_vld !== (NUMCLNT'(1) << mon_e.id) || bus.rsp_dout !== mon_e.data) begin
               miscompares++;
               $display("FAIL rsp_data: got vld=%b dout=%h, expected vld=%b dout=%h",
                        bus.rsp_vld, bus.rsp_dout, NUMCLNT'(1) << mon_e.id, mon_e.data);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_req();
      bus.cl_vld  = '0;
      bus.cl_wr   = '0;
      bus.cl_addr = '0;
      bus.cl_din  = '0;
   endtask

   task automatic set_req(input int unsigned c, input logic wr,
                          input logic [BITADDR-1:0] a, input logic [WIDTH-1:0] d);
      bus.cl_vld[c]                    = 1'b1;
      bus.cl_wr[c]                     = wr;
      bus.cl_addr[c*BITADDR +: BITADDR] = a;
      bus.cl_din[c*WIDTH +: WIDTH]     = d;
   endtask

   // Called mid-cycle: records granted reads, advances past the edge and
   // withdraws the granted requests.
   task automatic accept(input bit push);
      logic [NUMCLNT-1:0] g;
      logic [BITADDR-1:0] a;
      g = bus.cl_rdy;
      for (int unsigned c = 0; c < NUMCLNT; c++) begin
         if (push && g[c] && !bus.cl_wr[c]) begin
            a = bus.cl_addr[c*BITADDR +: BITADDR];
            sb_q.push_back('{id: clnt_id_t'(c), data: rom(a)});
         end
      end
      tick();
      bus.cl_vld = bus.cl_vld & ~g;
   endtask

   task automatic test_reset();
      logic bad;
      clear_req();
      bus.mem_ready = 1'b0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      vectors++;
      if (bus.read !== 1'b0 || bus.write !== 2'b00 || bus.addr !== '0 || bus.din !== '0 ||
          bus.rsp_vld !== '0 || bus.sched_err !== 1'b0 || bus.cl_rdy !== '0) begin
         miscompares++;
         $display("FAIL reset_outputs: read=%b write=%b addr=%h din=%h rsp=%b err=%b rdy=%b, expected all 0",
                  bus.read, bus.write, bus.addr, bus.din, bus.rsp_vld, bus.sched_err, bus.cl_rdy);
      end
`ifndef ALGO_SCHED_PERF_EN
      vectors++;
      if (bus.perf_rd_cnt !== 32'd0 || bus.perf_wr_cnt !== 32'd0 || bus.perf_stall_cnt !== 32'd0) begin
         miscompares++;
         $display("FAIL perf_tied: rd=%0d wr=%0d stall=%0d, expected 0",
                  bus.perf_rd_cnt, bus.perf_wr_cnt, bus.perf_stall_cnt);
      end
`endif
      rst = 1'b0;
      for (int unsigned c = 0; c < NUMCLNT; c++) set_req(c, 1'b0, BITADDR'(c), '0);
      bad = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (bus.cl_rdy !== '0 || bus.read !== 1'b0 || bus.write !== 2'b00) bad = 1'b1;
      end
      vectors++;
      if (bad) begin
         miscompares++;
         $display("FAIL not_ready_block: grants or memory ops seen with mem_ready=0, expected none");
      end
   endtask

   task automatic test_read_pair();
      tick();
      clear_req();
      bus.mem_ready = 1'b1;
      set_req(0, 1'b0, 13'd5, '0);
      set_req(1, 1'b0, 13'd6, '0);
      @(negedge clk);
      vectors++;
      if (bus.cl_rdy !== 4'b0001) begin
         miscompares++; $display("FAIL rd_grant0: cl_rdy=%b expected 0001", bus.cl_rdy);
      end
      accept(1'b1);
      @(negedge clk);
      vectors++;
      if (bus.cl_rdy !== 4'b0010 || bus.read !== 1'b1 || bus.write !== 2'b00 || bus.addr !== {13'd0, 13'd5}) begin
         miscompares++;
         $display("FAIL rd_issue0: rdy=%b read=%b write=%b addr=%h, expected 0010 1 00 %h",
                  bus.cl_rdy, bus.read, bus.write, bus.addr, {13'd0, 13'd5});
      end
      accept(1'b1);
      @(negedge clk);
      vectors++;
      if (bus.read !== 1'b1 || bus.addr !== {13'd0, 13'd6} || bus.rsp_vld !== 4'b0000) begin
         miscompares++;
         $display("FAIL rd_issue1: read=%b addr=%h rsp=%b, expected 1 %h 0000",
                  bus.read, bus.addr, bus.rsp_vld, {13'd0, 13'd6});
      end
      @(negedge clk);
      @(negedge clk);
      vectors++;
      if (bus.rsp_vld !== 4'b0001 || bus.rsp_dout !== rom(13'd5)) begin
         miscompares++;
         $display("FAIL rd_rsp0_time: rsp=%b dout=%h, expected 0001 %h", bus.rsp_vld, bus.rsp_dout, rom(13'd5));
      end
      @(negedge clk);
      vectors++;
      if (bus.rsp_vld !== 4'b0010 || bus.rsp_dout !== rom(13'd6)) begin
         miscompares++;
         $display("FAIL rd_rsp1_time: rsp=%b dout=%h, expected 0010 %h", bus.rsp_vld, bus.rsp_dout, rom(13'd6));
      end
   endtask

   task automatic test_write_burst();
      tick();
      set_req(3, 1'b1, 13'h40, 32'hD3D3_0040);
      @(negedge clk);
      vectors++;
      if (bus.cl_rdy !== 4'b1000) begin
         miscompares++; $display("FAIL ptr_after_reads: cl_rdy=%b expected 1000", bus.cl_rdy);
      end
      accept(1'b1);
      @(negedge clk);
      vectors++;
      if (bus.write !== 2'b01 || bus.read !== 1'b0 || bus.addr !== {13'd0, 13'h40} || bus.din !== {32'd0, 32'hD3D3_0040}) begin
         miscompares++;
         $display("FAIL lone_write: write=%b read=%b addr=%h din=%h, expected 01 0 slot0", bus.write, bus.read, bus.addr, bus.din);
      end
      tick();
      for (int unsigned c = 0; c < NUMCLNT; c++) set_req(c, 1'b1, BITADDR'(c + 1), 32'h1000 + c);
      @(negedge clk);
      vectors++;
      if (bus.cl_rdy !== 4'b0011) begin
         miscompares++; $display("FAIL wr_grant01: cl_rdy=%b expected 0011", bus.cl_rdy);
      end
      accept(1'b1);
      @(negedge clk);
      vectors++;
      if (bus.cl_rdy !== 4'b1100 || bus.write !== 2'b11 || bus.addr !== {13'd2, 13'd1} || bus.din !== {32'h1001, 32'h1000}) begin
         miscompares++;
         $display("FAIL wr_pair01: rdy=%b write=%b addr=%h din=%h, expected 1100 11 slots(0,1)", bus.cl_rdy, bus.write, bus.addr, bus.din);
      end
      accept(1'b1);
      @(negedge clk);
      vectors++;
      if (bus.cl_rdy !== 4'b0000 || bus.write !== 2'b11 || bus.addr !== {13'd4, 13'd3} || bus.din !== {32'h1003, 32'h1002}) begin
         miscompares++;
         $display("FAIL wr_pair23: rdy=%b write=%b addr=%h din=%h, expected 0000 11 slots(2,3)", bus.cl_rdy, bus.write, bus.addr, bus.din);
      end
      tick();
      set_req(1, 1'b0, 13'h30, '0);
      set_req(3, 1'b0, 13'h31, '0);
      @(negedge clk);
      vectors++;
      if (bus.cl_rdy !== 4'b0010) begin
         miscompares++; $display("FAIL ptr_wrap0: cl_rdy=%b expected 0010", bus.cl_rdy);
      end
      accept(1'b1);
      @(negedge clk);
      vectors++;
      if (bus.cl_rdy !== 4'b1000) begin
         miscompares++; $display("FAIL rd_rd_defer: cl_rdy=%b expected 1000", bus.cl_rdy);
      end
      accept(1'b1);
   endtask

   task automatic test_rd_wr_same_addr();
      tick();
      set_req(2, 1'b0, 13'h10, '0);
      set_req(3, 1'b1, 13'h10, 32'hCAFE_0010);
      @(negedge clk);
      vectors++;
      if (bus.cl_rdy !== 4'b1100) begin
         miscompares++; $display("FAIL rw_grant: cl_rdy=%b expected 1100", bus.cl_rdy);
      end
      accept(1'b1);
      @(negedge clk);
      vectors++;
      if (bus.read !== 1'b1 || bus.write !== 2'b10 || bus.addr !== {13'h10, 13'h10} || bus.din !== {32'hCAFE_0010, 32'd0}) begin
         miscompares++;
         $display("FAIL rw_slots: read=%b write=%b addr=%h din=%h, expected 1 10 both 0x10 din slot1",
                  bus.read, bus.write, bus.addr, bus.din);
      end
   endtask

   task automatic test_same_addr_writes();
      tick();
      set_req(0, 1'b1, 13'h7, 32'h70);
      set_req(1, 1'b1, 13'h7, 32'h71);
      set_req(2, 1'b1, 13'h8, 32'h72);
      @(negedge clk);
      vectors++;
      if (bus.cl_rdy !== 4'b0101) begin
         miscompares++; $display("FAIL ww_conflict_grant: cl_rdy=%b expected 0101", bus.cl_rdy);
      end
      accept(1'b1);
      @(negedge clk);
      vectors++;
      if (bus.cl_rdy !== 4'b0010 || bus.write !== 2'b11 || bus.addr !== {13'h8, 13'h7} || bus.din !== {32'h72, 32'h70}) begin
         miscompares++;
         $display("FAIL ww_conflict_issue: rdy=%b write=%b addr=%h din=%h, expected 0010 11 (7,8)", bus.cl_rdy, bus.write, bus.addr, bus.din);
      end
      accept(1'b1);
      @(negedge clk);
      vectors++;
      if (bus.write !== 2'b01 || bus.addr !== {13'd0, 13'h7} || bus.din !== {32'd0, 32'h71}) begin
         miscompares++;
         $display("FAIL ww_deferred: write=%b addr=%h din=%h, expected 01 slot0 0x7/0x71", bus.write, bus.addr, bus.din);
      end
      repeat (8) @(negedge clk);
      vectors++;
      if (sb_q.size() != 0 || bus.sched_err !== 1'b0) begin
         miscompares++;
         $display("FAIL drain: outstanding=%0d sched_err=%b, expected 0 0", sb_q.size(), bus.sched_err);
      end
   endtask

   task automatic test_err_and_reset();
      logic bad;
      tick();
      inj = 1'b1;
      @(negedge clk);
      vectors++;
      if (bus.rsp_vld !== 4'b0000) begin
         miscompares++; $display("FAIL stray_rdvld_rsp: rsp_vld=%b expected 0000", bus.rsp_vld);
      end
      tick();
      inj = 1'b0;
      vectors++;
      if (bus.sched_err !== 1'b1) begin
         miscompares++; $display("FAIL err_set: sched_err=%b expected 1", bus.sched_err);
      end
      repeat (4) tick();
      vectors++;
      if (bus.sched_err !== 1'b1) begin
         miscompares++; $display("FAIL err_sticky: sched_err=%b expected 1", bus.sched_err);
      end
      for (int unsigned c = 0; c < NUMCLNT; c++) set_req(c, 1'b0, BITADDR'(32'h50 + c), '0);
      @(negedge clk);
      accept(1'b0);
      @(negedge clk);
      accept(1'b0);
      #2;
      rst = 1'b1;
      #1;
      vectors++;
      if (bus.read !== 1'b0 || bus.write !== 2'b00 || bus.sched_err !== 1'b0 || bus.cl_rdy !== '0 || bus.rsp_vld !== '0) begin
         miscompares++;
         $display("FAIL async_rst: read=%b write=%b err=%b rdy=%b rsp=%b, expected all 0",
                  bus.read, bus.write, bus.sched_err, bus.cl_rdy, bus.rsp_vld);
      end
      clear_req();
      tick();
      rst = 1'b0;
      bad = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (bus.rsp_vld !== '0 || bus.sched_err !== 1'b0) bad = 1'b1;
      end
      vectors++;
      if (bad) begin
         miscompares++; $display("FAIL post_rst_quiet: response or sched_err after reset release, expected none");
      end
   endtask

   initial begin
      test_reset();
      test_read_pair();
      test_write_burst();
      test_rd_wr_same_addr();
      test_same_addr_writes();
      test_err_and_reset();
      vectors++;
      if (sb_q.size() != 0) begin
         miscompares++; $display("FAIL sb_empty: %0d responses never arrived, expected 0", sb_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
